// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and M-op decode helpers.
package alu_pkg;

  localparam int unsigned OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_m_op(input alu_op_e op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  // Operand A is treated as two's complement
  function automatic logic op_a_signed(input alu_op_e op);
    return op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
  endfunction

  // Operand B is treated as two's complement
  function automatic logic op_b_signed(input alu_op_e op);
    return op inside {ALU_MULH, ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between an ALU client (master) and alu_mc (slave).
interface alu_mc_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned SEL_W = 5;

  logic                  in_valid;
  logic                  in_ready;
  logic [SEL_W-1:0]      aluselect;
  logic [DATA_WIDTH-1:0] input0;
  logic [DATA_WIDTH-1:0] input1;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out;
  logic                  is_zero;

  modport master (
    output in_valid, aluselect, input0, input1, out_ready,
    input  in_ready, out_valid, out, is_zero
  );

  modport slave (
    input  in_valid, aluselect, input0, input1, out_ready,
    output in_ready, out_valid, out, is_zero
  );
endinterface

// File: rtl/muldiv_iter.sv
// Bit-serial shift-add multiplier and restoring divider; one bit per cycle, DATA_WIDTH cycles.
// Built only when ALU_M_EXT_EN is defined.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result_c
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(W) + 1;

  alu_op_e        op_q;
  logic           busy_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   quot_q;
  logic [W-1:0]   dvs_q;
  logic [W-1:0]   a_q;
  logic           b_zero_q;
  logic           neg_q_q;
  logic           neg_r_q;

  logic           sa_c, sb_c;
  logic [W-1:0]   mag_a_c, mag_b_c;
  logic [W:0]     trial_c, diff_c;

  // Both datapaths run on unsigned magnitudes; signs are reapplied at the end
  always_comb begin
    sa_c    = op_a_signed(op) & a[W-1];
    sb_c    = op_b_signed(op) & b[W-1];
    mag_a_c = sa_c ? (~a + W'(1)) : a;
    mag_b_c = sb_c ? (~b + W'(1)) : b;
    trial_c = {rem_q, quot_q[W-1]};
    diff_c  = trial_c - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= ALU_ADD;
      busy_q   <= 1'b0;
      done     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      b_zero_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else if (start) begin
      op_q     <= op;
      busy_q   <= 1'b1;
      done     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {W'(0), mag_a_c};
      mplier_q <= mag_b_c;
      rem_q    <= '0;
      quot_q   <= mag_a_c;
      dvs_q    <= mag_b_c;
      a_q      <= a;
      b_zero_q <= (b == '0);
      neg_q_q  <= sa_c ^ sb_c;
      neg_r_q  <= sa_c;
    end else if (busy_q && !done) begin
      acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[W-1:1]};
      if (!diff_c[W]) begin
        rem_q  <= diff_c[W-1:0];
        quot_q <= {quot_q[W-2:0], 1'b1};
      end else begin
        rem_q  <= trial_c[W-1:0];
        quot_q <= {quot_q[W-2:0], 1'b0};
      end
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) done <= 1'b1;
    end else if (done) begin
      done   <= 1'b0;
      busy_q <= 1'b0;
    end
  end

  logic [2*W-1:0] prod_c;
  logic [W-1:0]   q_c, r_c;

  // Sign fix-up; divide-by-zero overrides the raw quotient/remainder
  always_comb begin
    prod_c = neg_q_q ? (~acc_q + (2*W)'(1)) : acc_q;
    q_c    = neg_q_q ? (~quot_q + W'(1)) : quot_q;
    r_c    = neg_r_q ? (~rem_q + W'(1)) : rem_q;
    if (b_zero_q) begin
      q_c = '1;
      r_c = a_q;
    end
    case (op_q)
      ALU_MUL:                          result_c = prod_c[W-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:  result_c = prod_c[2*W-1:W];
      ALU_DIV, ALU_DIVU:                result_c = q_c;
      ALU_REM, ALU_REMU:                result_c = r_c;
      default:                          result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Non-pipelined ALU with valid/ready handshake; single-cycle base ops.
// Define ALU_M_EXT_EN to add the iterative multiply/divide ops via muldiv_iter.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);
  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  alu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  is_zero_q;
  logic                  out_valid_q;
  logic                  in_ready_q;

  alu_op_e               op_c;
  logic                  accept_c;
  logic [SHW-1:0]        shamt_c;
  logic [DATA_WIDTH-1:0] alu_res_c;

  assign op_c     = alu_op_e'(bus.aluselect);
  assign accept_c = bus.in_valid && in_ready_q;
  assign shamt_c  = bus.input1[SHW-1:0];

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.is_zero   = is_zero_q;

  // Single-cycle datapath, evaluated on the live operands at acceptance
  always_comb begin
    alu_res_c = '0;
    case (op_c)
      ALU_ADD:   alu_res_c = bus.input0 + bus.input1;
      ALU_SUB:   alu_res_c = bus.input0 - bus.input1;
      ALU_SLL:   alu_res_c = bus.input0 << shamt_c;
      ALU_SLT:   alu_res_c = DATA_WIDTH'($signed(bus.input0) < $signed(bus.input1));
      ALU_SLTU:  alu_res_c = DATA_WIDTH'(bus.input0 < bus.input1);
      ALU_XOR:   alu_res_c = bus.input0 ^ bus.input1;
      ALU_SRL:   alu_res_c = bus.input0 >> shamt_c;
      ALU_SRA:   alu_res_c = DATA_WIDTH'($signed(bus.input0) >>> shamt_c);
      ALU_OR:    alu_res_c = bus.input0 | bus.input1;
      ALU_AND:   alu_res_c = bus.input0 & bus.input1;
      ALU_PASSB: alu_res_c = bus.input1;
      default:   alu_res_c = '0;
    endcase
  end

`ifdef ALU_M_EXT_EN
  logic                  start_c;
  logic                  md_done;
  logic [DATA_WIDTH-1:0] md_result_c;

  muldiv_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_c),
    .op       (op_c),
    .a        (bus.input0),
    .b        (bus.input1),
    .done     (md_done),
    .result_c (md_result_c)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
`ifdef ALU_M_EXT_EN
    start_c = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
`ifdef ALU_M_EXT_EN
          if (is_m_op(op_c)) begin
            state_d = BUSY;
            start_c = 1'b1;
          end else
`endif
          begin
            state_d = DONE;
            out_d   = alu_res_c;
          end
        end
      end
      BUSY: begin
`ifdef ALU_M_EXT_EN
        if (md_done) begin
          state_d = DONE;
          out_d   = md_result_c;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      is_zero_q   <= 1'b1;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      out_q       <= out_d;
      is_zero_q   <= (out_d == '0);
      out_valid_q <= (state_d == DONE);
      in_ready_q  <= (state_d == IDLE);
    end
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter DATA_WIDTH SHALL be declared with default 32; it sets the operand and result width and must be a power of two, 8 or greater.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide: reset, asynchronous and active-low.
REQ-004 Port in_valid SHALL be an input, 1 bit wide: the operation request.
REQ-005 Port in_ready SHALL be an output, 1 bit wide: the unit can accept an operation.
REQ-006 Port aluselect SHALL be an input, 5 bits wide: the operation code, an alu_op_e value.
REQ-007 Port input0 SHALL be an input, DATA_WIDTH bits wide: operand A (rs1).
REQ-008 Port input1 SHALL be an input, DATA_WIDTH bits wide: operand B (rs2 or immediate).
REQ-009 Port out_valid SHALL be an output, 1 bit wide: the result is available.
REQ-010 Port out_ready SHALL be an input, 1 bit wide: the consumer accepts the result.
REQ-011 Port out SHALL be an output, DATA_WIDTH bits wide: the result.
REQ-012 Port is_zero SHALL be an output, 1 bit wide, equal to (out == 0).

Function
REQ-013 An operation is accepted only on a cycle where in_valid and in_ready are both 1; operands and aluselect are captured on that edge.
REQ-014 Single-cycle ops (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB) SHALL assert out_valid on the cycle after acceptance, with out registered.
REQ-015 Shift amount for SLL, SRL and SRA SHALL be input1[$clog2(DATA_WIDTH)-1:0]; SLT and SLTU SHALL return 0 or 1 zero-extended; all arithmetic wraps modulo 2^DATA_WIDTH.
REQ-016 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-017 FSM transitions: IDLE->DONE on accepting a single-cycle op; IDLE->BUSY on accepting a multi-cycle op; BUSY->DONE when the iteration count reaches DATA_WIDTH; DONE->IDLE on out_ready.
REQ-018 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-019 In DONE with out_ready=0, out, is_zero and out_valid SHALL hold stable.
REQ-020 The unit SHALL be non-pipelined: a new op is accepted in IDLE only, so maximum throughput is 1 op per 2 cycles.
REQ-021 An unknown aluselect value SHALL complete as a single-cycle op with out=0.

Reset
REQ-022 rst_n=0 SHALL immediately force state to IDLE, out_valid=0, out=0, and the iteration counter and internal accumulators to 0.
REQ-023 Because out=0 during reset, is_zero SHALL be 1 during reset.
REQ-024 A reset asserted during BUSY or DONE SHALL discard the operation with no output.
REQ-025 in_ready SHALL be 1 on the first clk edge after rst_n is released.

Configuration
REQ-026 Macro ALU_M_EXT_EN defined SHALL enable MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
REQ-027 These ops SHALL be iterative, one bit per cycle, with out_valid asserted exactly DATA_WIDTH+1 cycles after acceptance.
REQ-028 Divide by zero SHALL give a quotient of all ones and a remainder equal to input0.
REQ-029 Signed overflow (most-negative value / -1) SHALL give quotient = input0 and remainder = 0.
REQ-030 Without ALU_M_EXT_EN, the M opcodes SHALL be treated as unknown (REQ-021), the BUSY logic and muldiv_iter SHALL not be instantiated, and the FSM SHALL never enter BUSY.

Structure
REQ-031 Package alu_pkg SHALL hold the alu_op_e 5-bit enum (0-9 base ops, 10 PASSB, 16-23 M ops), the FSM state typedef, and the M-op helper functions.
REQ-032 Sub-module muldiv_iter SHALL hold the shift-add multiplier and the restoring divider, with start/done ports; it exists only under ALU_M_EXT_EN.

Verification
REQ-033 ADD, DATA_WIDTH=32, 0xFFFFFFFF + 1 -> out=0 and is_zero=1, one cycle after accept.
REQ-034 SRA of 0x80000000 by input1=0x23 (uses 3) -> out=0xF0000000.
REQ-035 Backpressure: SLTU 10,20 with out_ready=0 for 5 cycles -> out=1 held and in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-036 With ALU_M_EXT_EN: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; DIVU 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; each after 33 cycles.
REQ-037 Assert rst_n low mid-BUSY in cycle 10 of a MUL -> out_valid never rises; in_ready=1 after release.
REQ-038 Without ALU_M_EXT_EN: aluselect=MUL -> out=0 and is_zero=1 after 1 cycle; DATA_WIDTH=8 random single-cycle sweep matches the reference model.
